// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one data-memory port between the load/store unit (LSU) and
//   NUM_REQ secondary requesters. The LSU normally wins without waiting.
//   Secondaries are served round-robin in cycles the LSU leaves free. A
//   starvation counter forces one secondary through after the LSU has won
//   STARVE_LIMIT times in a row while secondaries were waiting. Read data is
//   routed back to its issuer READ_LAT cycles after the access, using a
//   tagged response pipeline.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   IN_lsu*                     LSU request / addr / wdata / we / wm
//   OUT_lsuStall                LSU refused this cycle, must retry
//   IN_req/addr/wdata/we/wm     packed secondary request vectors
//   OUT_gnt                     one-hot secondary grant (combinational)
//   OUT_MEM_*                   memory port, ce/we active-low
//   IN_MEM_data                 memory read data
//   OUT_rdata                   read response data (IN_MEM_data)
//   OUT_lsuRvalid, OUT_rvalid   response ownership
module mem_port_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int READ_LAT     = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    IN_lsuReq,
  input  logic [29:0]             IN_lsuAddr,
  input  logic [31:0]             IN_lsuData,
  input  logic                    IN_lsuWe,
  input  logic [3:0]              IN_lsuWm,
  output logic                    OUT_lsuStall,
  input  logic [NUM_REQ-1:0]      IN_req,
  input  logic [NUM_REQ*30-1:0]   IN_addr,
  input  logic [NUM_REQ*32-1:0]   IN_wdata,
  input  logic [NUM_REQ-1:0]      IN_we,
  input  logic [NUM_REQ*4-1:0]    IN_wm,
  output logic [NUM_REQ-1:0]      OUT_gnt,
  output logic [29:0]             OUT_MEM_addr,
  output logic [31:0]             OUT_MEM_data,
  output logic                    OUT_MEM_we,
  output logic                    OUT_MEM_ce,
  output logic [3:0]              OUT_MEM_wm,
  input  logic [31:0]             IN_MEM_data,
  output logic [31:0]             OUT_rdata,
  output logic                    OUT_lsuRvalid,
  output logic [NUM_REQ-1:0]      OUT_rvalid
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [RW-1:0]       rr;
  logic [7:0]          starve;
  logic [READ_LAT-1:0] pipe_v;
  logic [READ_LAT-1:0] pipe_lsu;
  logic [RW-1:0]       pipe_id [READ_LAT];

  logic          any_req;
  logic          force_sec;
  logic          lsu_win;
  logic          sec_win;
  logic          win_rd;
  logic [RW-1:0] sel;

  // First requesting index at or after start, wrapping modulo NUM_REQ.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] req, input int start);
    int j;
    rr_pick = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = start + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) rr_pick = j;
    end
  endfunction

  assign any_req   = |IN_req;
  assign force_sec = (starve == 8'(STARVE_LIMIT)) && any_req;

  // Reset gates every winner so the port stays idle while rst_n is low,
  // whatever the request inputs are doing.
  always_comb begin
    lsu_win = 1'b0;
    sec_win = 1'b0;
    sel     = '0;
    OUT_gnt = '0;
    if (rst_n) begin
      if (IN_lsuReq && !force_sec) begin
        lsu_win = 1'b1;
      end else if (any_req) begin
        sec_win = 1'b1;
        sel     = RW'(rr_pick(IN_req, int'(rr)));
        OUT_gnt[sel] = 1'b1;
      end
    end
  end

  assign OUT_lsuStall = !rst_n || (IN_lsuReq && !lsu_win);

  always_comb begin
    OUT_MEM_ce   = 1'b1;
    OUT_MEM_we   = 1'b1;
    OUT_MEM_addr = '0;
    OUT_MEM_data = '0;
    OUT_MEM_wm   = '0;
    win_rd       = 1'b0;
    if (lsu_win) begin
      OUT_MEM_ce   = 1'b0;
      OUT_MEM_we   = !IN_lsuWe;
      OUT_MEM_addr = IN_lsuAddr;
      OUT_MEM_data = IN_lsuData;
      OUT_MEM_wm   = IN_lsuWm;
      win_rd       = !IN_lsuWe;
    end else if (sec_win) begin
      OUT_MEM_ce   = 1'b0;
      OUT_MEM_we   = !IN_we[sel];
      OUT_MEM_addr = IN_addr[int'(sel)*30 +: 30];
      OUT_MEM_data = IN_wdata[int'(sel)*32 +: 32];
      OUT_MEM_wm   = IN_wm[int'(sel)*4 +: 4];
      win_rd       = !IN_we[sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr     <= '0;
      starve <= '0;
    end else begin
      if (sec_win) begin
        rr     <= (sel == RW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        starve <= '0;
      end else if (!any_req) begin
        starve <= '0;
      end else if (lsu_win && starve != 8'(STARVE_LIMIT)) begin
        starve <= starve + 8'd1;
      end
    end
  end

  // Tag pipeline: one tag enters per cycle, so reads and writes interleave
  // freely; writes enter with valid low and never produce a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v   <= '0;
      pipe_lsu <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_id[i] <= '0;
    end else begin
      pipe_v[0]   <= win_rd;
      pipe_lsu[0] <= lsu_win;
      pipe_id[0]  <= sel;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_lsu[i] <= pipe_lsu[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  assign OUT_rdata     = IN_MEM_data;
  assign OUT_lsuRvalid = pipe_v[READ_LAT-1] && pipe_lsu[READ_LAT-1];

  always_comb begin
    OUT_rvalid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      OUT_rvalid[k] = pipe_v[READ_LAT-1] && !pipe_lsu[READ_LAT-1]
                      && (pipe_id[READ_LAT-1] == RW'(k));
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with NUM_REQ=3, READ_LAT=1,
//   STARVE_LIMIT=8. Inputs change 1 time unit after a rising edge and
//   outputs are checked 2 units later, well clear of either clock edge.
module tb_mem_port_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lsu_req;
  logic [29:0]   lsu_addr;
  logic [31:0]   lsu_data;
  logic          lsu_we;
  logic [3:0]    lsu_wm;
  logic          lsu_stall;
  logic [N-1:0]  req;
  logic [N*30-1:0] addr;
  logic [N*32-1:0] wdata;
  logic [N-1:0]  we;
  logic [N*4-1:0] wm;
  logic [N-1:0]  gnt;
  logic [29:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          mem_ce;
  logic [3:0]    mem_wm;
  logic [31:0]   mem_rdata;
  logic [31:0]   rdata;
  logic          lsu_rvalid;
  logic [N-1:0]  rvalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(3), .READ_LAT(1), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .IN_lsuReq(lsu_req), .IN_lsuAddr(lsu_addr), .IN_lsuData(lsu_data),
    .IN_lsuWe(lsu_we), .IN_lsuWm(lsu_wm), .OUT_lsuStall(lsu_stall),
    .IN_req(req), .IN_addr(addr), .IN_wdata(wdata), .IN_we(we), .IN_wm(wm),
    .OUT_gnt(gnt),
    .OUT_MEM_addr(mem_addr), .OUT_MEM_data(mem_wdata), .OUT_MEM_we(mem_we),
    .OUT_MEM_ce(mem_ce), .OUT_MEM_wm(mem_wm), .IN_MEM_data(mem_rdata),
    .OUT_rdata(rdata), .OUT_lsuRvalid(lsu_rvalid), .OUT_rvalid(rvalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    lsu_req = 1'b1; lsu_addr = 30'h100; lsu_data = 32'h0; lsu_we = 1'b0; lsu_wm = 4'h0;
    req = 3'b111; we = '0; wm = '0; mem_rdata = 32'h0;
    for (int k = 0; k < N; k++) begin
      addr[k*30 +: 30]  = 30'h1000 + 30'(k);
      wdata[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    end

    // Reset holds the port idle even with every request asserted.
    #2;
    chk("rst_ce", mem_ce, 1);
    chk("rst_we", mem_we, 1);
    chk("rst_stall", lsu_stall, 1);
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", {lsu_rvalid, rvalid}, 0);
    lsu_req = 1'b0; req = '0;
    #10 rst_n = 1'b1;

    // LSU alone: idle cycles 0..2, read 0x100 in cycle 3.
    tick();
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("idle_ce", mem_ce, 1);
      chk("idle_stall", lsu_stall, 0);
      tick();
    end
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 30'h100;
    #2;
    chk("lsu_ce", mem_ce, 0);
    chk("lsu_we", mem_we, 1);
    chk("lsu_addr", mem_addr, 32'h100);
    chk("lsu_stall", lsu_stall, 0);
    chk("lsu_gnt", gnt, 0);
    chk("lsu_rv_early", lsu_rvalid, 0);
    tick();
    lsu_req = 1'b0; mem_rdata = 32'hDEADBEEF;
    #2;
    chk("lsu_rvalid", lsu_rvalid, 1);
    chk("lsu_rdata", rdata, 32'hDEADBEEF);
    chk("lsu_rv_sec", rvalid, 0);
    chk("lsu_stall2", lsu_stall, 0);
    tick();
    mem_rdata = 32'h0;
    #2;
    chk("lsu_rv_clear", lsu_rvalid, 0);

    // Round-robin: all three requesting (reads), then drop req[1].
    tick();
    req = 3'b111;
    #2; chk("rr0_gnt", gnt, 3'b001); chk("rr0_addr", mem_addr, 32'h1000);
    tick();
    #2; chk("rr1_gnt", gnt, 3'b010); chk("rr1_addr", mem_addr, 32'h1001);
        chk("rr1_rvalid", rvalid, 3'b001);
    tick();
    #2; chk("rr2_gnt", gnt, 3'b100); chk("rr2_rvalid", rvalid, 3'b010);
    tick();
    #2; chk("rr3_gnt", gnt, 3'b001); chk("rr3_rvalid", rvalid, 3'b100);
    tick();
    req = 3'b101;
    #2; chk("rr4_gnt", gnt, 3'b100);
    tick();
    #2; chk("rr5_gnt", gnt, 3'b001);
    tick();
    #2; chk("rr6_gnt", gnt, 3'b100);
    tick();
    req = 3'b000;
    #2; chk("rr_idle_ce", mem_ce, 1); chk("rr_idle_rvalid", rvalid, 3'b100);

    // Starvation: LSU every cycle, secondary 1 waiting.
    tick();
    lsu_req = 1'b1; lsu_addr = 30'h300; req = 3'b010;
    for (int c = 0; c < 8; c++) begin
      #2;
      chk("st_lsu_stall", lsu_stall, 0);
      chk("st_lsu_gnt", gnt, 0);
      tick();
    end
    #2;
    chk("st8_stall", lsu_stall, 1);
    chk("st8_gnt", gnt, 3'b010);
    chk("st8_addr", mem_addr, 32'h1001);
    chk("st8_ce", mem_ce, 0);
    tick();
    #2;
    chk("st9_stall", lsu_stall, 0);
    chk("st9_gnt", gnt, 0);
    chk("st9_rvalid", rvalid, 3'b010);
    chk("st9_lsurv", lsu_rvalid, 0);
    tick();
    lsu_req = 1'b0; req = 3'b000;

    // Secondary 2: write in cycle 0, read in cycle 1.
    tick();
    req = 3'b100; we = 3'b100; wm[8 +: 4] = 4'b0011;
    #2;
    chk("wr_gnt", gnt, 3'b100);
    chk("wr_ce", mem_ce, 0);
    chk("wr_we", mem_we, 0);
    chk("wr_wm", mem_wm, 4'b0011);
    chk("wr_data", mem_wdata, 32'hA000_0002);
    tick();
    we = 3'b000;
    #2;
    chk("rd_ce", mem_ce, 0);
    chk("rd_we", mem_we, 1);
    chk("wr_no_resp", rvalid, 0);
    tick();
    req = 3'b001;
    #2;
    chk("rd_resp", rvalid, 3'b100);
    chk("rd_resp_lsu", lsu_rvalid, 0);
    chk("pre_rst_gnt", gnt, 3'b001);
    tick();
    req = 3'b000;
    #2;
    chk("pre_rst_rvalid", rvalid, 3'b001);

    // Reset with an LSU read in flight; rr is 1 at this point.
    tick();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 30'h200;
    #2;
    chk("inflt_ce", mem_ce, 0);
    chk("inflt_stall", lsu_stall, 0);
    tick();
    lsu_req = 1'b0; req = 3'b111;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ce", mem_ce, 1);
    chk("mid_rst_we", mem_we, 1);
    chk("mid_rst_stall", lsu_stall, 1);
    chk("mid_rst_lsurv", lsu_rvalid, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_gnt", gnt, 0);
    tick();
    #1 rst_n = 1'b1;
    #1;
    chk("rel_gnt", gnt, 3'b001);
    chk("rel_lsurv", lsu_rvalid, 0);
    tick();
    #2;
    chk("rel2_gnt", gnt, 3'b010);
    chk("rel2_lsurv", lsu_rvalid, 0);
    chk("rel2_rvalid", rvalid, 3'b001);
    req = 3'b000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
